// File: rtl/dff_pipe_pkg.sv
// Shared definitions for the dff_pipe elastic register pipeline.
// Holds default geometry and the occupancy-counter width helper.
// Optional occupancy port is enabled with the DFF_PIPE_OCC_EN macro.
package dff_pipe_pkg;

  localparam int unsigned DFF_PIPE_WIDTH_DEF = 8;
  localparam int unsigned DFF_PIPE_DEPTH_DEF = 4;

  // Bits needed to count 0..depth valid stages.
  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One stage of the elastic pipeline: valid bit plus WIDTH-bit data register.
// Latency: 1 cycle when load_i is high; holds otherwise.
// Backpressure: load_i comes from the parent's advance chain; stage holds when it is low.
// Ports: clk, rst/flush (sync clear), load_i (advance), src_vld_i/src_dat_i (upstream),
//        vld_o/dat_o (registered stage contents).
module dff_pipe_stage
  import dff_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = DFF_PIPE_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load_i,
  input  logic             src_vld_i,
  input  logic [WIDTH-1:0] src_dat_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] dat_o
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q, dat_d;

  // Data only moves with a valid source word; a bubble clears the valid
  // bit but leaves the data register untouched, so garbage on an idle
  // source never lands in the pipe.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (load_i) begin
      vld_d = src_vld_i;
      if (src_vld_i) begin
        dat_d = src_dat_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_q <= 1'b0;
      dat_q <= RESET_VAL;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/dff_pipe.sv
// Elastic DEPTH-stage WIDTH-bit register pipeline with per-stage valid and bubble collapsing.
// Latency: DEPTH cycles from input accept to out_valid with no stalls; 1 word/cycle sustained.
// Backpressure: in_ready is combinational from out_ready through the advance chain; flush forces in_ready low.
// Ports: clk, rst (sync, active-high), flush (sync clear), in_valid/in_ready/in_data (producer side),
//        out_valid/out_ready/out_data (consumer side), occ (valid-stage count, only with DFF_PIPE_OCC_EN).
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = DFF_PIPE_WIDTH_DEF,
  parameter int unsigned      DEPTH     = DFF_PIPE_DEPTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data
`ifdef DFF_PIPE_OCC_EN
  ,
  output logic [occ_w(DEPTH)-1:0]  occ
`endif
);

  logic [DEPTH-1:0]            stage_vld;
  logic [DEPTH-1:0][WIDTH-1:0] stage_dat;
  logic [DEPTH-1:0]            adv;
  logic [DEPTH-1:0]            src_vld;
  logic [DEPTH-1:0][WIDTH-1:0] src_dat;

  // Advance chain, unrolled: stage i may move unless every stage from i to
  // the output is occupied and the consumer is stalling. Written with a
  // running AND so no bit of adv depends on another bit of adv.
  always_comb begin
    logic all_full;
    adv      = '0;
    all_full = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      all_full = all_full & stage_vld[i];
      adv[i]   = out_ready | ~all_full;
    end
  end

  // Source of each stage: the producer for stage 0, the previous stage otherwise.
  always_comb begin
    src_vld    = '0;
    src_dat    = '0;
    src_vld[0] = in_valid;
    src_dat[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_vld[i] = stage_vld[i-1];
      src_dat[i] = stage_dat[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    dff_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .load_i    (adv[g]),
      .src_vld_i (src_vld[g]),
      .src_dat_i (src_dat[g]),
      .vld_o     (stage_vld[g]),
      .dat_o     (stage_dat[g])
    );
  end

  // Stages still see adv during a flush, but their own clear wins; masking
  // in_ready keeps the producer from believing a word was taken.
  assign in_ready  = adv[0] & ~flush;
  assign out_valid = stage_vld[DEPTH-1];
  assign out_data  = stage_dat[DEPTH-1];

`ifdef DFF_PIPE_OCC_EN
  localparam int unsigned OCC_W = occ_w(DEPTH);

  logic [OCC_W-1:0] occ_q, occ_d;
  logic             in_xfer, out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    occ_d = occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ = occ_q;

  a_occ_matches_valid : assert property (
    @(posedge clk) disable iff (rst) occ_q == OCC_W'($countones(stage_vld))
  );
`endif

endmodule

// File: tb/tb_dff_pipe.sv
module tb_dff_pipe;

  localparam logic [7:0] RV = 8'h5A;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  logic       flush1;
  logic       in_valid1;
  logic       in_ready1;
  logic [0:0] in_data1;
  logic       out_valid1;
  logic       out_ready1;
  logic [0:0] out_data1;

`ifdef DFF_PIPE_OCC_EN
  logic [2:0] occ;
  logic [0:0] occ1;
`endif

  dff_pipe #(
    .WIDTH     (8),
    .DEPTH     (4),
    .RESET_VAL (RV)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DFF_PIPE_OCC_EN
    ,
    .occ       (occ)
`endif
  );

  dff_pipe #(
    .WIDTH     (1),
    .DEPTH     (1),
    .RESET_VAL (1'b0)
  ) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush1),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_data   (in_data1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_data  (out_data1)
`ifdef DFF_PIPE_OCC_EN
    ,
    .occ       (occ1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       fl;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    int         e_occ;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic row(input logic iv, input logic [7:0] d, input logic ordy, input logic fl,
                     input logic e_ir, input logic e_ov, input logic [7:0] e_od, input int e_occ);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ;
    tbl.push_back(v);
  endtask

  // Sample away from the active edge and run the scoreboard for the main DUT.
  task automatic sample();
    logic [7:0] exp;
    @(negedge clk);
    cyc++;
    if (out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: got %0h with no word expected (cycle %0d)", out_data, cyc);
      end else begin
        exp = sb.pop_front();
        checks--;
        chk("sb_data", 32'(out_data), 32'(exp));
      end
    end
    if (in_valid && in_ready) sb.push_back(in_data);
    if (rst || flush) sb.delete();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent, outs, gaps, t_acc, t_out, last, seen;

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    flush1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
    advance();

    // Reset with random traffic on every input.
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid  = 1'($urandom);
      in_data   = 8'($urandom);
      out_ready = 1'($urandom);
      flush     = 1'($urandom);
      in_valid1 = 1'($urandom);
      in_data1  = 1'($urandom);
      out_ready1 = 1'($urandom);
      flush1    = 1'($urandom);
      sample();
      advance();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
    sample();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'(RV));
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst1_out_valid", 32'(out_valid1), 32'd0);
    chk("rst1_in_ready",  32'(in_ready1),  32'd1);
`ifdef DFF_PIPE_OCC_EN
    chk("rst_occ",  32'(occ),  32'd0);
    chk("rst1_occ", 32'(occ1), 32'd0);
`endif
    advance();

    // Full stall and drain, bubble collapse, flush with 3 words held.
    row(1, 8'h11, 0, 0,  1, 0, RV,    0);
    row(1, 8'h22, 0, 0,  1, 0, RV,    1);
    row(1, 8'h33, 0, 0,  1, 0, RV,    2);
    row(1, 8'h44, 0, 0,  1, 0, RV,    3);
    row(1, 8'h55, 0, 0,  0, 1, 8'h11, 4);
    row(0, 8'h00, 0, 0,  0, 1, 8'h11, 4);
    row(0, 8'h00, 1, 0,  1, 1, 8'h11, 4);
    row(0, 8'h00, 1, 0,  1, 1, 8'h22, 3);
    row(0, 8'h00, 1, 0,  1, 1, 8'h33, 2);
    row(0, 8'h00, 1, 0,  1, 1, 8'h44, 1);
    row(0, 8'h00, 1, 0,  1, 0, 8'h44, 0);
    row(1, 8'hA1, 0, 0,  1, 0, 8'h44, 0);
    row(0, 8'h00, 0, 0,  1, 0, 8'h44, 1);
    row(1, 8'hB2, 0, 0,  1, 0, 8'h44, 1);
    row(0, 8'h00, 0, 0,  1, 0, 8'h44, 2);
    row(0, 8'h00, 0, 0,  1, 1, 8'hA1, 2);
    row(1, 8'hC3, 0, 0,  1, 1, 8'hA1, 2);
    row(1, 8'hD4, 0, 0,  1, 1, 8'hA1, 3);
    row(1, 8'hE5, 0, 0,  0, 1, 8'hA1, 4);
    row(0, 8'h00, 1, 0,  1, 1, 8'hA1, 4);
    row(1, 8'hF6, 1, 1,  0, 1, 8'hB2, 3);
    row(0, 8'h00, 0, 0,  1, 0, RV,    0);

    for (int k = 0; k < tbl.size(); k++) begin
      in_valid  = tbl[k].iv;
      in_data   = tbl[k].iv ? tbl[k].d : 8'($urandom);
      out_ready = tbl[k].ordy;
      flush     = tbl[k].fl;
      sample();
      chk($sformatf("tbl%0d_in_ready", k),  32'(in_ready),  32'(tbl[k].e_ir));
      chk($sformatf("tbl%0d_out_valid", k), 32'(out_valid), 32'(tbl[k].e_ov));
      chk($sformatf("tbl%0d_out_data", k),  32'(out_data),  32'(tbl[k].e_od));
`ifdef DFF_PIPE_OCC_EN
      chk($sformatf("tbl%0d_occ", k), 32'(occ), 32'(tbl[k].e_occ));
`endif
      advance();
    end
    flush = 1'b0;
    chk("tbl_sb_empty", 32'(sb.size()), 32'd0);

    // Streaming 0x01..0x10 with out_ready held high.
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    sample();
    advance();
    rst = 1'b0;
    sent = 0; outs = 0; gaps = 0; t_acc = -1; t_out = -1; last = -1;
    for (int k = 0; k < 60; k++) begin
      if (sent >= 16 && outs >= 16) break;
      in_valid  = (sent < 16);
      in_data   = 8'(sent + 1);
      out_ready = 1'b1;
      sample();
      if (in_valid && in_ready) begin
        if (sent == 0) t_acc = cyc;
        sent++;
      end
      if (out_valid) begin
        if (outs == 0) t_out = cyc;
        else if (cyc != last + 1) gaps++;
        last = cyc;
        outs++;
      end
      advance();
    end
    chk("stream_latency", 32'(t_out - t_acc), 32'd4);
    chk("stream_count",   32'(outs), 32'd16);
    chk("stream_gaps",    32'(gaps), 32'd0);
    chk("stream_sb_empty", 32'(sb.size()), 32'd0);

    // Reset in the middle of a stall discards everything.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h70 + k);
      sample();
      advance();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    sample();
    advance();
    rst = 1'b0;
    sample();
    chk("stall_rst_out_valid", 32'(out_valid), 32'd0);
    chk("stall_rst_out_data",  32'(out_data),  32'(RV));
    chk("stall_rst_in_ready",  32'(in_ready),  32'd1);
`ifdef DFF_PIPE_OCC_EN
    chk("stall_rst_occ", 32'(occ), 32'd0);
`endif
    advance();
    out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      sample();
      if (out_valid) seen++;
      advance();
    end
    chk("stall_rst_no_words", 32'(seen), 32'd0);
    out_ready = 1'b0;

    // DEPTH=1, WIDTH=1: simultaneous in/out transfer while full.
    in_valid1 = 1'b1; in_data1 = 1'b1; out_ready1 = 1'b0;
    sample();
    chk("d1_fill_in_ready", 32'(in_ready1), 32'd1);
    chk("d1_fill_out_valid", 32'(out_valid1), 32'd0);
    advance();
    in_valid1 = 1'b1; in_data1 = 1'b0; out_ready1 = 1'b0;
    sample();
    chk("d1_full_in_ready", 32'(in_ready1), 32'd0);
    chk("d1_full_out_valid", 32'(out_valid1), 32'd1);
    chk("d1_full_out_data", 32'(out_data1), 32'd1);
`ifdef DFF_PIPE_OCC_EN
    chk("d1_full_occ", 32'(occ1), 32'd1);
`endif
    advance();
    out_ready1 = 1'b1;
    sample();
    chk("d1_swap_in_ready", 32'(in_ready1), 32'd1);
    chk("d1_swap_out_data", 32'(out_data1), 32'd1);
    advance();
    in_valid1 = 1'b0; in_data1 = 1'b1;
    sample();
    chk("d1_after_out_valid", 32'(out_valid1), 32'd1);
    chk("d1_after_out_data", 32'(out_data1), 32'd0);
`ifdef DFF_PIPE_OCC_EN
    chk("d1_after_occ", 32'(occ1), 32'd1);
`endif
    advance();
    out_ready1 = 1'b0;
    sample();
    chk("d1_empty_out_valid", 32'(out_valid1), 32'd0);
    chk("d1_empty_out_data", 32'(out_data1), 32'd0);
    chk("d1_empty_in_ready", 32'(in_ready1), 32'd1);
`ifdef DFF_PIPE_OCC_EN
    chk("d1_empty_occ", 32'(occ1), 32'd0);
`endif
    advance();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
